zorro_dma_sequencer: RTL and testbench
======================================

Name: zorro_dma_sequencer

Overview:
- Sequences a complete SCSI DMA transfer (start address, byte count, direction) as a series of single Zorro III master cycles.
- Drives the per-cycle DMA master through its start / acknowledge / active handshake.
- Per cycle: picks the transfer size from alignment and remaining count, advances the address, and inserts fairness gaps between bursts.
- Sits between the NCR53C710 DMA request logic / register block and the Zorro DMA master FSM.

Parameters:
- MAX_BURST, 4: master cycles issued back-to-back before a forced idle gap (1..15).
- GAP_CYCLES, 2: idle clocks inserted after each MAX_BURST cycles (1..15).
- TIMEOUT, 255: clocks to wait for DMA_ACK before faulting (1..255).

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- GO  in  1  one-clock pulse; latches descriptor and starts a transfer.
- DIR  in  1  1 = read from Zorro into NCR; 0 = write to Zorro. Sampled with GO.
- START_ADDR  in  32  byte start address. Sampled with GO.
- BYTE_COUNT  in  24  bytes to move. Sampled with GO.
- ABORT  in  1  level; requests early termination.
- BUSY  out  1  high from the clock after an accepted GO until DONE or fault.
- DONE  out  1  one-clock pulse at end of transfer (normal or aborted).
- ABORTED  out  1  set when DONE results from ABORT; cleared by next accepted GO.
- ERROR  out  1  set on ack timeout; cleared by next accepted GO.
- CUR_ADDR  out  32  address of next cycle to issue.
- REMAIN  out  24  bytes not yet acknowledged.
- DMA_START  out  1  one-clock start pulse to the master.
- DMA_READ  out  1  direction to the master; equals latched DIR.
- DMA_ADDR  out  32  cycle address; stable from DMA_START until DMA_ACK.
- DMA_SIZ  out  2  68030 encoding: 00 long, 01 byte, 10 word.
- DMA_ACK  in  1  one-clock pulse from master: cycle complete.
- DMA_ACTIVE  in  1  master busy.

Behaviour:

Reset:
- All outputs 0; state IDLE; counters 0.
- Reset mid-transfer abandons it with no DONE pulse.

States: IDLE, ISSUE, WAIT_ACK, NEXT, GAP, FINISH, FAULT.

- IDLE:
  - GO with BYTE_COUNT != 0: latch descriptor, clear ERROR/ABORTED, go to ISSUE; BUSY=1 next clock.
  - GO with BYTE_COUNT == 0: go to FINISH; DONE pulses on the 2nd clock after GO; no DMA_START.
  - GO while BUSY is ignored.
- ISSUE:
  - Wait while DMA_ACTIVE=1.
  - When DMA_ACTIVE=0: assert DMA_START for exactly one clock, latch size and address, go to WAIT_ACK.
  - ABORT sampled in ISSUE goes to FINISH (ABORTED=1) without issuing.
- Size rule, evaluated on CUR_ADDR/REMAIN:
  - Long (SIZ 00, 4 bytes) if addr[1:0]==0 and REMAIN>=4.
  - Otherwise word (SIZ 10, 2 bytes) if addr[0]==0 and REMAIN>=2.
  - Otherwise byte (SIZ 01, 1 byte).
- WAIT_ACK:
  - Timeout counter runs from 0.
  - On DMA_ACK: CUR_ADDR += size, REMAIN -= size, burst count +1; go to NEXT.
  - CUR_ADDR wraps modulo 2^32 with no error.
  - Counter reaching TIMEOUT without ACK: go to FAULT.
  - ABORT during WAIT_ACK is held pending; the in-flight cycle always completes.
- NEXT (one clock):
  - REMAIN==0 or pending abort: go to FINISH.
  - Burst count == MAX_BURST: clear burst count, go to GAP.
  - Otherwise go to ISSUE.
- GAP:
  - Hold for GAP_CYCLES clocks, then go to ISSUE.
  - ABORT during GAP goes to FINISH.
- FINISH:
  - DONE=1 for one clock, BUSY=0, then go to IDLE.
  - ABORTED=1 if the exit was caused by abort.
- FAULT:
  - ERROR=1 and BUSY=0 in the same clock; go to IDLE. No DONE pulse.
  - The master is not cancelled. A late DMA_ACK arriving in IDLE is ignored.
- ABORT and DMA_ACK in the same clock: the ACK is counted, then the transfer finishes as aborted.
- DMA_START is never asserted while DMA_ACTIVE=1 or while BUSY=0.

Test Plan:
- GO, addr 0x0020_0000, count 12, DIR=1, ACK 3 clocks after each start → 3 long cycles at 0x…00/04/08, SIZ 00, DMA_READ=1, REMAIN 12→8→4→0, one DONE pulse, ERROR=0.
- GO, addr 0x0000_1001, count 7 → cycles: byte@1001, word@1002, long@1004; REMAIN 0; final CUR_ADDR 0x1008.
- Count 40, MAX_BURST=4, GAP_CYCLES=2 → after every 4th ACK, no DMA_START for ≥3 clocks (NEXT + 2 GAP); 10 cycles total.
- Withhold DMA_ACK → ERROR=1 exactly TIMEOUT clocks after DMA_START's following clock; BUSY=0; no DONE; next GO clears ERROR.
- ABORT asserted during 2nd WAIT_ACK of a 16-byte transfer → 2nd cycle completes, REMAIN=8, DONE pulses, ABORTED=1, no 3rd DMA_START.
- GO with count 0 → DONE on 2nd clock, no DMA_START. GO pulsed while BUSY → ignored, descriptor unchanged. RESET mid-WAIT_ACK → all outputs 0 asynchronously.

Source files
------------

// File: rtl/zorro_dma_sequencer.sv
// Splits a SCSI DMA descriptor into single Zorro III master cycles, choosing
// the cycle size per step, inserting fairness gaps and timing out lost acks.
`timescale 1ns/1ps
module zorro_dma_sequencer #(
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        go_i,
    input  logic        dir_i,
    input  logic [31:0] start_addr_i,
    input  logic [23:0] byte_count_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        aborted_o,
    output logic        error_o,
    output logic [31:0] cur_addr_o,
    output logic [23:0] remain_o,
    output logic        dma_start_o,
    output logic        dma_read_o,
    output logic [31:0] dma_addr_o,
    output logic [1:0]  dma_siz_o,
    input  logic        dma_ack_i,
    input  logic        dma_active_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_GAP, S_FINISH, S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic [31:0] addr_q, addr_d;
    logic [23:0] rem_q, rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic        error_q, error_d;
    logic        start_q, start_d;
    logic [31:0] daddr_q, daddr_d;
    logic [1:0]  siz_q, siz_d;
    logic [2:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  burst_q, burst_d;
    logic        pend_q, pend_d;
    logic        abt_q, abt_d;

    logic [1:0]  siz_c;
    logic [2:0]  len_c;

    // Largest naturally aligned size that still fits in the remaining count
    always_comb begin
        siz_c = 2'b01;
        len_c = 3'd1;
        if (addr_q[1:0] == 2'b00 && rem_q >= 24'd4) begin
            siz_c = 2'b00;
            len_c = 3'd4;
        end else if (!addr_q[0] && rem_q >= 24'd2) begin
            siz_c = 2'b10;
            len_c = 3'd2;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = aborted_q;
        error_d   = error_q;
        start_d   = 1'b0;
        daddr_d   = daddr_q;
        siz_d     = siz_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        pend_d    = pend_q;
        abt_d     = abt_q;
        unique case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    busy_d    = 1'b1;
                    error_d   = 1'b0;
                    aborted_d = 1'b0;
                    dir_d     = dir_i;
                    addr_d    = start_addr_i;
                    rem_d     = byte_count_i;
                    burst_d   = 4'd0;
                    pend_d    = 1'b0;
                    abt_d     = 1'b0;
                    state_d   = (byte_count_i != 24'd0) ? S_ISSUE : S_FINISH;
                end
            end
            S_ISSUE: begin
                if (abort_i || pend_q) begin
                    abt_d   = 1'b1;
                    state_d = S_FINISH;
                end else if (!dma_active_i) begin
                    start_d = 1'b1;
                    daddr_d = addr_q;
                    siz_d   = siz_c;
                    len_d   = len_c;
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Abort only takes effect once the in-flight cycle has acked
                if (abort_i) pend_d = 1'b1;
                if (dma_ack_i) begin
                    addr_d  = addr_q + {29'd0, len_q};
                    rem_d   = rem_q - {21'd0, len_q};
                    burst_d = burst_q + 4'd1;
                    state_d = S_NEXT;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_NEXT: begin
                if (rem_q == 24'd0 || pend_q || abort_i) begin
                    abt_d   = pend_q || abort_i;
                    state_d = S_FINISH;
                end else if (burst_q == 4'(MAX_BURST)) begin
                    burst_d = 4'd0;
                    cnt_d   = 8'd0;
                    state_d = S_GAP;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_GAP: begin
                if (abort_i || pend_q) begin
                    abt_d   = 1'b1;
                    state_d = S_FINISH;
                end else if (cnt_q == 8'(GAP_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_FINISH: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                aborted_d = abt_q;
                state_d   = S_IDLE;
            end
            S_FAULT: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            addr_q    <= 32'd0;
            rem_q     <= 24'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            error_q   <= 1'b0;
            start_q   <= 1'b0;
            daddr_q   <= 32'd0;
            siz_q     <= 2'b00;
            len_q     <= 3'd0;
            cnt_q     <= 8'd0;
            burst_q   <= 4'd0;
            pend_q    <= 1'b0;
            abt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            error_q   <= error_d;
            start_q   <= start_d;
            daddr_q   <= daddr_d;
            siz_q     <= siz_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            pend_q    <= pend_d;
            abt_q     <= abt_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign error_o     = error_q;
    assign cur_addr_o  = addr_q;
    assign remain_o    = rem_q;
    assign dma_start_o = start_q;
    assign dma_read_o  = dir_q;
    assign dma_addr_o  = daddr_q;
    assign dma_siz_o   = siz_q;

endmodule

// File: tb/tb_zorro_dma_sequencer.sv
// Randomised and directed bench for zorro_dma_sequencer against a
// descriptor-level model of the cycle sequence.
`timescale 1ns/1ps
module tb_zorro_dma_sequencer;

    localparam int MB = 4;
    localparam int GC = 2;
    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        go_i = 1'b0;
    logic        dir_i = 1'b0;
    logic [31:0] start_addr_i = '0;
    logic [23:0] byte_count_i = '0;
    logic        abort_i = 1'b0;
    logic        dma_ack_i = 1'b0;
    logic        dma_active_i = 1'b0;
    logic        busy_o, done_o, aborted_o, error_o;
    logic [31:0] cur_addr_o, dma_addr_o;
    logic [23:0] remain_o;
    logic        dma_start_o, dma_read_o;
    logic [1:0]  dma_siz_o;

    zorro_dma_sequencer #(.MAX_BURST(MB), .GAP_CYCLES(GC), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .go_i(go_i), .dir_i(dir_i),
        .start_addr_i(start_addr_i), .byte_count_i(byte_count_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
        .aborted_o(aborted_o), .error_o(error_o), .cur_addr_o(cur_addr_o),
        .remain_o(remain_o), .dma_start_o(dma_start_o),
        .dma_read_o(dma_read_o), .dma_addr_o(dma_addr_o),
        .dma_siz_o(dma_siz_o), .dma_ack_i(dma_ack_i),
        .dma_active_i(dma_active_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;

    int ack_lat = 2;
    int ack_tail = 0;
    bit ack_en = 1'b1;
    bit mclr = 1'b0;
    int pend = 0;
    int tail = 0;
    int done_cnt = 0;
    int viol = 0;

    logic [31:0] st_addr[$];
    logic [1:0]  st_siz[$];
    logic        st_rd[$];
    logic [23:0] st_rem[$];
    int          st_cyc[$];
    int          ack_cyc[$];

    logic [31:0] exp_addr[$];
    logic [1:0]  exp_siz[$];
    logic [23:0] exp_rem[$];

    // Zorro master stand-in: ack after ack_lat clocks, optional busy tail
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i || mclr) begin
                pend = 0;
                tail = 0;
                dma_ack_i = 1'b0;
                dma_active_i = 1'b0;
                mclr = 1'b0;
            end else begin
                if (done_o) done_cnt++;
                if (dma_start_o && (dma_active_i || !busy_o)) viol++;
                if (dma_start_o) begin
                    st_addr.push_back(dma_addr_o);
                    st_siz.push_back(dma_siz_o);
                    st_rd.push_back(dma_read_o);
                    st_rem.push_back(remain_o);
                    st_cyc.push_back(cyc);
                end
                dma_ack_i = 1'b0;
                if (tail > 0) begin
                    tail--;
                    if (tail == 0) dma_active_i = 1'b0;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        dma_ack_i = 1'b1;
                        ack_cyc.push_back(cyc);
                        if (ack_tail == 0) dma_active_i = 1'b0;
                        else tail = ack_tail;
                    end
                end
                if (dma_start_o) begin
                    dma_active_i = 1'b1;
                    if (ack_en) pend = ack_lat;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mon();
        st_addr.delete(); st_siz.delete(); st_rd.delete();
        st_rem.delete(); st_cyc.delete(); ack_cyc.delete();
    endtask

    task automatic build_model(input logic [31:0] a0, input int n);
        logic [31:0] a;
        int r;
        int s;
        a = a0;
        r = n;
        exp_addr.delete(); exp_siz.delete(); exp_rem.delete();
        while (r > 0) begin
            if (a % 4 == 0 && r >= 4) s = 4;
            else if (a % 2 == 0 && r >= 2) s = 2;
            else s = 1;
            exp_addr.push_back(a);
            exp_siz.push_back(s == 4 ? 2'b00 : (s == 2 ? 2'b10 : 2'b01));
            exp_rem.push_back(24'(r));
            a = a + 32'(s);
            r = r - s;
        end
    endtask

    function automatic bit seq_ok(input logic rd);
        if (st_addr.size() != exp_addr.size()) return 1'b0;
        foreach (exp_addr[i]) begin
            if (st_addr[i] !== exp_addr[i] || st_siz[i] !== exp_siz[i] ||
                st_rem[i] !== exp_rem[i] || st_rd[i] !== rd) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic do_go(input logic [31:0] a, input int n, input logic d);
        @(negedge clk_i); #1;
        go_i = 1'b1;
        start_addr_i = a;
        byte_count_i = 24'(n);
        dir_i = d;
        @(negedge clk_i); #1;
        go_i = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i); #1;
            if (done_o || error_o) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_starts(input int n, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i); #1;
            if (st_addr.size() >= n) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        total_cnt++;
        if ({busy_o, done_o, aborted_o, error_o, dma_start_o, dma_read_o,
             dma_siz_o, cur_addr_o, remain_o, dma_addr_o} !== '0)
            $display("FAIL reset_outputs: got busy=%b err=%b addr=%h rem=%h",
                     busy_o, error_o, cur_addr_o, remain_o);
        else pass_cnt++;
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_aligned();
        bit hit;
        int d0;
        clear_mon();
        ack_lat = 3; ack_tail = 0;
        d0 = done_cnt;
        build_model(32'h0020_0000, 12);
        do_go(32'h0020_0000, 12, 1'b1);
        wait_end(200, hit);
        total_cnt++;
        if (!(hit && done_o && !error_o))
            $display("FAIL aligned_done: got hit=%b done=%b err=%b want 1 1 0",
                     hit, done_o, error_o);
        else pass_cnt++;
        repeat (3) @(negedge clk_i); #1;
        total_cnt++;
        if (!seq_ok(1'b1))
            $display("FAIL aligned_seq: got %0d cycles want %0d",
                     st_addr.size(), exp_addr.size());
        else pass_cnt++;
        total_cnt++;
        if (cur_addr_o !== 32'h0020_000C || remain_o !== 24'd0)
            $display("FAIL aligned_final: got addr=%h rem=%0d want 0020000c 0",
                     cur_addr_o, remain_o);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 !== 1)
            $display("FAIL aligned_donecnt: got %0d want 1", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_unaligned();
        bit hit;
        clear_mon();
        ack_lat = 2; ack_tail = 1;
        build_model(32'h0000_1001, 7);
        do_go(32'h0000_1001, 7, 1'b0);
        wait_end(200, hit);
        repeat (2) @(negedge clk_i); #1;
        total_cnt++;
        if (!hit || !seq_ok(1'b0))
            $display("FAIL unaligned_seq: got hit=%b n=%0d want 1 %0d",
                     hit, st_addr.size(), exp_addr.size());
        else pass_cnt++;
        total_cnt++;
        if (cur_addr_o !== 32'h0000_1008 || remain_o !== 24'd0)
            $display("FAIL unaligned_final: got addr=%h rem=%0d want 00001008 0",
                     cur_addr_o, remain_o);
        else pass_cnt++;
    endtask

    task automatic test_gap();
        bit hit;
        bit ok;
        int dn;
        int dg;
        clear_mon();
        ack_lat = 2; ack_tail = 0;
        build_model(32'h0000_0100, 40);
        do_go(32'h0000_0100, 40, 1'b1);
        wait_end(400, hit);
        repeat (2) @(negedge clk_i); #1;
        total_cnt++;
        if (!hit || !seq_ok(1'b1) || st_addr.size() != 10)
            $display("FAIL gap_seq: got hit=%b n=%0d want 1 10", hit, st_addr.size());
        else pass_cnt++;
        ok = (st_cyc.size() == 10 && ack_cyc.size() == 10);
        dn = ok ? st_cyc[1] - ack_cyc[0] : 0;
        dg = 0;
        if (ok) begin
            for (int k = 1; k < 10; k++) begin
                if (k % MB == 0) begin
                    dg = st_cyc[k] - ack_cyc[k-1];
                    if (dg < 4 || dg != dn + GC) ok = 1'b0;
                end else if (st_cyc[k] - ack_cyc[k-1] != dn) begin
                    ok = 1'b0;
                end
            end
        end
        total_cnt++;
        if (!ok)
            $display("FAIL gap_timing: got normal=%0d gap=%0d want gap=normal+%0d >=4",
                     dn, dg, GC);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit hit;
        int d0;
        int s;
        int k;
        clear_mon();
        ack_en = 1'b0;
        d0 = done_cnt;
        do_go(32'h0000_0400, 8, 1'b0);
        wait_starts(1, 50, hit);
        s = hit ? st_cyc[0] : 0;
        k = -1;
        for (int i = 0; i < 100 && hit; i++) begin
            if (error_o) begin
                k = cyc - s;
                break;
            end
            @(negedge clk_i); #1;
        end
        total_cnt++;
        if (k !== TO + 1)
            $display("FAIL timeout_latency: got %0d want %0d", k, TO + 1);
        else pass_cnt++;
        total_cnt++;
        if (busy_o !== 1'b0 || done_cnt !== d0)
            $display("FAIL timeout_state: got busy=%b dones=%0d want 0 0",
                     busy_o, done_cnt - d0);
        else pass_cnt++;
        mclr = 1'b1;
        ack_en = 1'b1;
        ack_lat = 1;
        do_go(32'h0000_0500, 2, 1'b0);
        total_cnt++;
        if (error_o !== 1'b0)
            $display("FAIL timeout_clear: got err=%b want 0", error_o);
        else pass_cnt++;
        wait_end(100, hit);
    endtask

    task automatic test_abort();
        bit hit;
        bit hit2;
        clear_mon();
        ack_lat = 3; ack_tail = 0;
        do_go(32'h0000_0800, 16, 1'b1);
        wait_starts(2, 100, hit);
        abort_i = 1'b1;
        wait_end(100, hit2);
        total_cnt++;
        if (!(hit && hit2 && done_o && aborted_o && !error_o))
            $display("FAIL abort_done: got done=%b aborted=%b err=%b want 1 1 0",
                     done_o, aborted_o, error_o);
        else pass_cnt++;
        abort_i = 1'b0;
        repeat (6) @(negedge clk_i); #1;
        total_cnt++;
        if (st_addr.size() != 2 || remain_o !== 24'd8 || cur_addr_o !== 32'h0000_0808)
            $display("FAIL abort_state: got n=%0d rem=%0d addr=%h want 2 8 00000808",
                     st_addr.size(), remain_o, cur_addr_o);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        logic [2:0] dv;
        clear_mon();
        @(negedge clk_i); #1;
        go_i = 1'b1;
        byte_count_i = 24'd0;
        start_addr_i = 32'h0000_0A00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); #1;
            go_i = 1'b0;
            dv[i] = done_o;
        end
        total_cnt++;
        if (dv !== 3'b010)
            $display("FAIL zero_done: got done seq=%b want 010", dv);
        else pass_cnt++;
        total_cnt++;
        if (st_addr.size() != 0 || aborted_o !== 1'b0)
            $display("FAIL zero_nostart: got starts=%0d aborted=%b want 0 0",
                     st_addr.size(), aborted_o);
        else pass_cnt++;
    endtask

    task automatic test_go_busy();
        bit hit;
        clear_mon();
        ack_lat = 4; ack_tail = 0;
        build_model(32'h0000_3000, 8);
        do_go(32'h0000_3000, 8, 1'b1);
        wait_starts(1, 50, hit);
        do_go(32'h0000_9001, 20, 1'b0);
        wait_end(200, hit);
        repeat (8) @(negedge clk_i); #1;
        total_cnt++;
        if (!seq_ok(1'b1) || cur_addr_o !== 32'h0000_3008 || busy_o !== 1'b0)
            $display("FAIL go_busy: got n=%0d addr=%h busy=%b want %0d 00003008 0",
                     st_addr.size(), cur_addr_o, busy_o, exp_addr.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit hit;
        int d0;
        clear_mon();
        ack_en = 1'b0;
        d0 = done_cnt;
        do_go(32'h0000_0600, 8, 1'b1);
        wait_starts(1, 50, hit);
        @(negedge clk_i); #2;
        rst_i = 1'b1;
        #1;
        total_cnt++;
        if (!hit || {busy_o, done_o, aborted_o, error_o, dma_start_o, dma_read_o,
             dma_siz_o, cur_addr_o, remain_o, dma_addr_o} !== '0)
            $display("FAIL reset_mid: got busy=%b read=%b addr=%h rem=%h want all 0",
                     busy_o, dma_read_o, cur_addr_o, remain_o);
        else pass_cnt++;
        @(negedge clk_i); #1;
        rst_i = 1'b0;
        ack_en = 1'b1;
        repeat (6) @(negedge clk_i); #1;
        total_cnt++;
        if (done_cnt !== d0 || busy_o !== 1'b0)
            $display("FAIL reset_nodone: got dones=%0d busy=%b want 0 0",
                     done_cnt - d0, busy_o);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit hit;
        logic [31:0] a;
        int n;
        logic d;
        for (int it = 0; it < 20; it++) begin
            clear_mon();
            a = $urandom;
            if (it % 5 == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            n = $urandom_range(1, 40);
            d = 1'($urandom_range(0, 1));
            ack_lat = $urandom_range(1, 4);
            ack_tail = $urandom_range(0, 2);
            build_model(a, n);
            do_go(a, n, d);
            wait_end(600, hit);
            repeat (2) @(negedge clk_i); #1;
            total_cnt++;
            if (!hit || !seq_ok(d))
                $display("FAIL rand_seq[%0d]: got n=%0d want %0d (a=%h cnt=%0d)",
                         it, st_addr.size(), exp_addr.size(), a, n);
            else pass_cnt++;
            total_cnt++;
            if (cur_addr_o !== a + 32'(n) || remain_o !== 24'd0 ||
                error_o !== 1'b0 || aborted_o !== 1'b0)
                $display("FAIL rand_final[%0d]: got addr=%h rem=%0d want %h 0",
                         it, cur_addr_o, remain_o, a + 32'(n));
            else pass_cnt++;
        end
        total_cnt++;
        if (viol !== 0)
            $display("FAIL start_rule: got %0d bad starts want 0", viol);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_unaligned();
        test_gap();
        test_timeout();
        test_abort();
        test_zero();
        test_go_busy();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
